// File: rtl/ifid_decode_stage_pkg.sv
// ifid_pkg: MIPS instruction field widths, opcode constants and the R/I/J
// instruction class used by the IF/ID decode stage and its field decoder.
package ifid_pkg;

   localparam int INSTR_W = 32;
   localparam int OPC_W   = 6;
   localparam int REG_W   = 5;
   localparam int FUNCT_W = 6;
   localparam int IMM_W   = 16;
   localparam int ADDR_W  = 26;

   localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
   localparam logic [OPC_W-1:0] OPC_J     = 6'h02;
   localparam logic [OPC_W-1:0] OPC_JAL   = 6'h03;

   typedef enum logic [1:0] {
      CLS_R,
      CLS_I,
      CLS_J
   } instr_cls_e;

   // Every opcode that is neither SPECIAL nor J/JAL is treated as I-format.
   function automatic instr_cls_e classify(input logic [OPC_W-1:0] opc);
      instr_cls_e cls;
      cls = CLS_I;
      if (opc == OPC_RTYPE) begin
         cls = CLS_R;
      end else if ((opc == OPC_J) || (opc == OPC_JAL)) begin
         cls = CLS_J;
      end
      return cls;
   endfunction

endpackage

// File: rtl/ifid_decode_stage_if.sv
// ifid_decode_stage_if: instruction input handshake plus decoded output
// stream of the IF/ID stage.
//   in_valid/in_ready/in_instr[/in_pc]  : upstream beat
//   out_valid/out_ready + decoded fields : downstream presentation
// Optional macro IFID_PC_EN adds in_pc / out_pc.
// modport master: the stage side; modport slave: the fetch/decode environment.
interface ifid_decode_stage_if #(
   parameter int XLEN = 32,
   parameter int PC_W = 32
);
   logic                          in_valid;
   logic                          in_ready;
   logic [ifid_pkg::INSTR_W-1:0]  in_instr;
   logic                          out_valid;
   logic                          out_ready;
   logic [ifid_pkg::OPC_W-1:0]    opcode;
   logic [ifid_pkg::REG_W-1:0]    rs;
   logic [ifid_pkg::REG_W-1:0]    rt;
   logic [ifid_pkg::REG_W-1:0]    rd;
   logic [ifid_pkg::REG_W-1:0]    shamt;
   logic [ifid_pkg::FUNCT_W-1:0]  funct;
   logic [XLEN-1:0]               imm_sext;
   logic [XLEN-1:0]               imm_zext;
   logic [PC_W-1:0]               jtarget;
   logic                          is_rtype;
   logic                          is_jtype;
   logic                          is_itype;
`ifdef IFID_PC_EN
   logic [PC_W-1:0]               in_pc;
   logic [PC_W-1:0]               out_pc;

   modport master (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
             imm_sext, imm_zext, jtarget, is_rtype, is_jtype, is_itype, out_pc
   );
   modport slave (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
             imm_sext, imm_zext, jtarget, is_rtype, is_jtype, is_itype, out_pc
   );
`else
   modport master (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
             imm_sext, imm_zext, jtarget, is_rtype, is_jtype, is_itype
   );
   modport slave (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
             imm_sext, imm_zext, jtarget, is_rtype, is_jtype, is_itype
   );
`endif
endinterface

// File: rtl/ifid_decode_stage_decoder.sv
// instr_field_decoder: purely combinational MIPS field splitter.
//   in : instr (32b), pc (PC_W, only with IFID_PC_EN)
//   out: opcode, rs, rt, rd, shamt, funct, imm_sext/imm_zext (XLEN),
//        jtarget (PC_W), is_rtype/is_jtype/is_itype
// Macro IFID_PC_EN: jtarget takes its upper bits from pc; otherwise the
// 28-bit target is zero-extended.
module instr_field_decoder
   import ifid_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic [INSTR_W-1:0] instr,
`ifdef IFID_PC_EN
   input  logic [PC_W-1:0]    pc,
`endif
   output logic [OPC_W-1:0]   opcode,
   output logic [REG_W-1:0]   rs,
   output logic [REG_W-1:0]   rt,
   output logic [REG_W-1:0]   rd,
   output logic [REG_W-1:0]   shamt,
   output logic [FUNCT_W-1:0] funct,
   output logic [XLEN-1:0]    imm_sext,
   output logic [XLEN-1:0]    imm_zext,
   output logic [PC_W-1:0]    jtarget,
   output logic               is_rtype,
   output logic               is_jtype,
   output logic               is_itype
);

   instr_cls_e cls;

   function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
      return XLEN'($signed(imm));
   endfunction

   function automatic logic [XLEN-1:0] zext_imm(input logic [IMM_W-1:0] imm);
      return XLEN'(imm);
   endfunction

   always_comb begin
      opcode   = instr[31:26];
      rs       = instr[25:21];
      rt       = instr[20:16];
      rd       = instr[15:11];
      shamt    = instr[10:6];
      funct    = instr[5:0];
      imm_sext = sext_imm(instr[IMM_W-1:0]);
      imm_zext = zext_imm(instr[IMM_W-1:0]);
      cls      = classify(instr[31:26]);
      is_rtype = (cls == CLS_R);
      is_jtype = (cls == CLS_J);
      is_itype = (cls == CLS_I);
   end

`ifdef IFID_PC_EN
   // Region bits above the 28-bit word target come from PC+4.
   if (PC_W > 28) begin : g_jt_region
      assign jtarget = {pc[PC_W-1:28], instr[ADDR_W-1:0], 2'b00};
   end else begin : g_jt_flat
      assign jtarget = PC_W'({instr[ADDR_W-1:0], 2'b00});
   end
`else
   assign jtarget = PC_W'({instr[ADDR_W-1:0], 2'b00});
`endif

endmodule

// File: rtl/ifid_decode_stage.sv
// ifid_decode_stage: registered IF/ID boundary with a two-entry skid buffer
// (main + skid) and combinational field decode of the main entry.
//   clk, rst (sync, active-high), flush (drop all held beats)
//   bus : ifid_decode_stage_if.master (input handshake, decoded outputs)
// Macro IFID_PC_EN: stores PC+4 per entry, exposes in_pc/out_pc and forms
// jtarget from the PC region bits.
module ifid_decode_stage
   import ifid_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   ifid_decode_stage_if.master         bus
);

   logic               main_vld;
   logic [INSTR_W-1:0] main_instr;
   logic               skid_vld;
   logic [INSTR_W-1:0] skid_instr;
   logic               in_fire;
   logic               main_free;
`ifdef IFID_PC_EN
   logic [PC_W-1:0]    main_pc;
   logic [PC_W-1:0]    skid_pc;
`endif

   // Ready depends only on registered state, never on out_ready.
   assign bus.in_ready  = !skid_vld && !rst;
   assign bus.out_valid = main_vld;
   assign in_fire       = bus.in_valid && bus.in_ready;
   // Main can take a new beat when empty or leaving this cycle.
   assign main_free     = !main_vld || bus.out_ready;

   // Stage boundary: fetch side -> held main/skid entries
   always_ff @(posedge clk) begin
      if (rst) begin
         main_vld   <= 1'b0;
         skid_vld   <= 1'b0;
         main_instr <= '0;
         skid_instr <= '0;
`ifdef IFID_PC_EN
         main_pc    <= '0;
         skid_pc    <= '0;
`endif
      end else if (flush) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
      end else if (main_free) begin
         if (skid_vld) begin
            // in_ready was low, so no input competes with the refill.
            main_vld   <= 1'b1;
            main_instr <= skid_instr;
`ifdef IFID_PC_EN
            main_pc    <= skid_pc;
`endif
            skid_vld   <= 1'b0;
         end else begin
            main_vld <= in_fire;
            if (in_fire) begin
               main_instr <= bus.in_instr;
`ifdef IFID_PC_EN
               main_pc    <= bus.in_pc;
`endif
            end
         end
      end else if (in_fire) begin
         skid_vld   <= 1'b1;
         skid_instr <= bus.in_instr;
`ifdef IFID_PC_EN
         skid_pc    <= bus.in_pc;
`endif
      end
   end

`ifdef IFID_PC_EN
   assign bus.out_pc = main_pc;
`endif

   // Stage boundary: main entry -> combinational decode outputs
   instr_field_decoder #(
      .XLEN (XLEN),
      .PC_W (PC_W)
   ) u_dec (
      .instr    (main_instr),
`ifdef IFID_PC_EN
      .pc       (main_pc),
`endif
      .opcode   (bus.opcode),
      .rs       (bus.rs),
      .rt       (bus.rt),
      .rd       (bus.rd),
      .shamt    (bus.shamt),
      .funct    (bus.funct),
      .imm_sext (bus.imm_sext),
      .imm_zext (bus.imm_zext),
      .jtarget  (bus.jtarget),
      .is_rtype (bus.is_rtype),
      .is_jtype (bus.is_jtype),
      .is_itype (bus.is_itype)
   );

endmodule

// File: tb/tb_ifid_decode_stage.sv
// tb_ifid_decode_stage: scoreboard bench for ifid_decode_stage.
// Accepted beats are queued with their instr/pc; each output transfer pops
// the oldest entry and compares every decoded field with a reference model.
// Directed checks cover reset, the example instructions, skid back-pressure,
// flush and mid-stream reset. Optional macro IFID_PC_EN adds pc checks.
module tb_ifid_decode_stage;

   localparam int XLEN = 32;
   localparam int PC_W = 32;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } beat_t;

   logic clk;
   logic rst;
   logic flush;

   int n_checks;
   int n_fail;

   beat_t sb[$];
   logic [31:0] drv_pc;

   ifid_decode_stage_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

   ifid_decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference decode: {opcode,rs,rt,rd,shamt,funct,sext,zext,jtarget,r,j,i}
   function automatic logic [159:0] model(input logic [31:0] i, input logic [31:0] pc);
      logic [5:0]  op;
      logic [31:0] sx;
      logic [31:0] zx;
      logic [31:0] jt;
      logic        r, j;
      op = i[31:26];
      sx = {{16{i[15]}}, i[15:0]};
      zx = {16'h0000, i[15:0]};
`ifdef IFID_PC_EN
      jt = {pc[31:28], i[25:0], 2'b00};
`else
      jt = {4'h0, i[25:0], 2'b00};
      if (pc != 32'h0) jt = jt; // pc unused in this build
`endif
      r = (op == 6'h00);
      j = (op == 6'h02) || (op == 6'h03);
      return 160'({op, i[25:21], i[20:16], i[15:11], i[10:6], i[5:0],
                   sx, zx, jt, r, j, !(r || j)});
   endfunction

   function automatic logic [159:0] dut_fields();
      return 160'({bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct,
                   bus.imm_sext, bus.imm_zext, bus.jtarget,
                   bus.is_rtype, bus.is_jtype, bus.is_itype});
   endfunction

   // Scoreboard: inputs are stable at negedge; transfers happen next posedge.
   always @(negedge clk) begin
      if (rst || flush) begin
         sb.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_depth", 160'(sb.size()), 160'd1);
            end else begin
               beat_t e;
               e = sb.pop_front();
               chk("sb_fields", dut_fields(), model(e.instr, e.pc));
`ifdef IFID_PC_EN
               chk("sb_pc", 160'(bus.out_pc), 160'(e.pc));
`endif
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back('{instr: bus.in_instr, pc: drv_pc});
         end
      end
   end

`ifdef IFID_PC_EN
   assign bus.in_pc = drv_pc;
`endif

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      drv_pc       = pc;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'h0;
      bus.out_ready = 1'b0;
      drv_pc        = 32'h0;
      step();
      step();

      // Reset state
      chk("rst_out_valid", 160'(bus.out_valid), 160'd0);
      chk("rst_in_ready",  160'(bus.in_ready),  160'd0);
      chk("rst_fields",    dut_fields(), model(32'h0, 32'h0));
      chk("rst_is_rtype",  160'(bus.is_rtype),  160'd1);

      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 160'(bus.in_ready), 160'd1);

      // addi $t0,$t1,-1
      bus.out_ready = 1'b1;
      offer(32'h2128FFFF, 32'h00000104);
      step();
      bus.in_valid = 1'b0;
      chk("addi_valid",  160'(bus.out_valid), 160'd1);
      chk("addi_opcode", 160'(bus.opcode),    160'h08);
      chk("addi_rs_rt",  160'({bus.rs, bus.rt}), 160'({5'd9, 5'd8}));
      chk("addi_sext",   160'(bus.imm_sext),  160'hFFFFFFFF);
      chk("addi_zext",   160'(bus.imm_zext),  160'h0000FFFF);
      chk("addi_itype",  160'({bus.is_rtype, bus.is_jtype, bus.is_itype}), 160'b001);

      // add $t2,$t0,$t1
      offer(32'h01095020, 32'h00000108);
      step();
      bus.in_valid = 1'b0;
      chk("add_regs",  160'({bus.rs, bus.rt, bus.rd, bus.shamt}),
          160'({5'd8, 5'd9, 5'd10, 5'd0}));
      chk("add_funct", 160'(bus.funct), 160'h20);
      chk("add_rtype", 160'({bus.is_rtype, bus.is_jtype, bus.is_itype}), 160'b100);

      // j 0x00400000
      offer(32'h08100000, 32'h00400004);
      step();
      bus.in_valid = 1'b0;
      chk("j_target", 160'(bus.jtarget), 160'h00400000);
      chk("j_jtype",  160'({bus.is_rtype, bus.is_jtype, bus.is_itype}), 160'b010);
      step();
      chk("idle_valid", 160'(bus.out_valid), 160'd0);

      // Back-pressure: A presented, B into skid, C stalled
      bus.out_ready = 1'b0;
      offer(32'h00000820, 32'h10);  // rd=1
      step();
      offer(32'h00001020, 32'h14);  // rd=2
      step();
      chk("bp_in_ready_b", 160'(bus.in_ready), 160'd0);
      chk("bp_main_a",     160'(bus.rd),       160'd1);
      offer(32'h00001820, 32'h18);  // rd=3
      step();
      chk("bp_hold_a",     160'({bus.out_valid, bus.rd}), 160'({1'b1, 5'd1}));
      chk("bp_in_ready_c", 160'(bus.in_ready), 160'd0);
      bus.out_ready = 1'b1;
      step();
      chk("bp_out_b", 160'({bus.out_valid, bus.rd}), 160'({1'b1, 5'd2}));
      step();
      bus.in_valid = 1'b0;
      chk("bp_out_c", 160'({bus.out_valid, bus.rd}), 160'({1'b1, 5'd3}));
      step();
      chk("bp_empty", 160'(bus.out_valid), 160'd0);

      // Flush with main and skid both full plus a live input
      bus.out_ready = 1'b0;
      offer(32'h00002020, 32'h20);
      step();
      offer(32'h00002820, 32'h24);
      step();
      chk("fl_full", 160'({bus.out_valid, bus.in_ready}), 160'b10);
      flush = 1'b1;
      offer(32'h00003020, 32'h28);
      step();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl_after", 160'({bus.out_valid, bus.in_ready}), 160'b01);
      bus.out_ready = 1'b1;
      step();
      step();
      chk("fl_gone", 160'(bus.out_valid), 160'd0);

      // Streaming then reset mid-stream
      offer(32'h8C880004, 32'h30);
      step();
      offer(32'h0C000040, 32'h34);
      step();
      chk("stream_valid", 160'(bus.out_valid), 160'd1);
      offer(32'h3508ABCD, 32'h38);
      rst = 1'b1;
      step();
      chk("mid_rst_state", 160'({bus.out_valid, bus.in_ready}), 160'b00);
      chk("mid_rst_fields", dut_fields(), model(32'h0, 32'h0));
`ifdef IFID_PC_EN
      chk("mid_rst_pc", 160'(bus.out_pc), 160'd0);
`endif
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("restart_ready", 160'(bus.in_ready), 160'd1);
      offer(32'h3508ABCD, 32'h3C);
      step();
      bus.in_valid = 1'b0;
      chk("restart_ori", 160'({bus.out_valid, bus.imm_zext}), 160'({1'b1, 32'h0000ABCD}));
      step();

      // Random traffic with back-pressure and occasional flush
      for (int c = 0; c < 400; c++) begin
         logic [31:0] w;
         w = $urandom;
         case ($urandom_range(0, 3))
            0: w[31:26] = 6'h00;
            1: w[31:26] = 6'h02 + 6'($urandom_range(0, 1));
            default: ;
         endcase
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_instr  = w;
         drv_pc        = $urandom;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         flush         = ($urandom_range(0, 60) == 0);
         step();
      end
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 10 && bus.out_valid; c++) step();
      chk("drain_done", 160'(bus.out_valid), 160'd0);
      @(negedge clk);
      chk("sb_drained", 160'(sb.size()), 160'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ifid_decode_stage.md
# ifid_decode_stage

Registered IF/ID boundary stage that accepts 32-bit MIPS instructions over a valid/ready handshake, holds them in a two-entry skid buffer, and presents fully split and extended fields to the decode/control logic. It extends the plain combinational field splitter with:
- parametrised immediate and PC widths;
- shamt extraction, sign and zero immediate extension, jump-target formation and R/I/J classification;
- back-pressure and pipeline flush.

## Interface
Parameters:
- XLEN, 32, width of extended immediates (≥16)
- PC_W, 32, program-counter width (≥28)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all held instructions (branch/jump redirect)
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept a beat
- in_instr  in  32  raw instruction word
- in_pc  in  PC_W  PC+4 of instruction (only with IFID_PC_EN)
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  downstream accepts
- opcode  out  6  instr[31:26]
- rs  out  5  instr[25:21]
- rt  out  5  instr[20:16]
- rd  out  5  instr[15:11]
- shamt  out  5  instr[10:6]
- funct  out  6  instr[5:0]
- imm_sext  out  XLEN  instr[15:0] sign-extended
- imm_zext  out  XLEN  instr[15:0] zero-extended
- jtarget  out  PC_W  jump target (see Configuration)
- is_rtype  out  1  opcode == 6'h00
- is_jtype  out  1  opcode == 6'h02 or 6'h03
- is_itype  out  1  neither R nor J
- out_pc  out  PC_W  PC+4 of presented instruction (only with IFID_PC_EN)

## Operation
- Storage is two entries: main (drives outputs) and skid. Each entry holds {valid, instr, pc}. Field outputs decode combinationally from main.instr.
- in_ready = !skid.valid && !rst. It is purely registered-state based, with no combinational path from out_ready.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Per cycle, when not flushing:
  - Main empty, or main draining with skid empty: the incoming beat loads main.
  - Main held (out_ready=0) with an incoming beat: the beat loads skid.
  - Main draining with skid full: skid moves to main and skid clears. In_ready was 0 that cycle, so there is no simultaneous input.
- Order is strictly FIFO. No beat is dropped or duplicated.
- flush = 1: both valids clear at the next edge and any same-cycle input beat is discarded. Flush has priority over all transfers.
- Reset and flush both clear the valids. Reset also zeroes the stored instr and pc, so all field outputs read 0 after reset. With instr = 0, is_rtype = 1.
- When out_valid = 0, field outputs reflect stale main contents. Consumers must qualify them with out_valid.

## Timing
- Latency: an input beat accepted at edge N is presented with out_valid=1 after edge N.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- During reset: out_valid=0 and in_ready=0. In the first cycle after rst deasserts, in_ready=1.
- When out_ready falls, at most one further beat is absorbed (into skid). in_ready is 0 in the following cycle.
- After a flush edge: out_valid=0 and in_ready=1.
- Reset asserted mid-transfer: all state is lost, with the same result as a flush.

## Configuration
- Macro: IFID_PC_EN.
- Defined:
  - in_pc and out_pc ports exist and pc is stored per entry.
  - jtarget = {main.pc[PC_W-1:28], instr[25:0], 2'b00}.
- Undefined:
  - No pc ports or storage.
  - jtarget = {instr[25:0], 2'b00}, zero-extended to PC_W.

## Structure
- Package ifid_pkg holds:
  - field-width localparams (OPC_W=6, REG_W=5, FUNCT_W=6, IMM_W=16, ADDR_W=26);
  - opcode constants OPC_RTYPE=6'h00, OPC_J=6'h02, OPC_JAL=6'h03;
  - class enum {CLS_R, CLS_I, CLS_J}.
- Sub-module instr_field_decoder: purely combinational. Takes instr (and pc) in; produces all field, extension, target and class outputs. The stage instantiates it once on main.

## Test plan
- Reset, then in_instr=32'h2128FFFF (addi $t0,$t1,-1) with out_ready=1. Next cycle:
  - out_valid=1, opcode=6'h08, rs=9, rt=8;
  - imm_sext=32'hFFFFFFFF, imm_zext=32'h0000FFFF, is_itype=1.
- in_instr=32'h01095020 (add $t2,$t0,$t1). Expect rs=8, rt=9, rd=10, shamt=0, funct=6'h20, is_rtype=1.
- IFID_PC_EN defined: in_instr=32'h08100000 (j), in_pc=32'h00400004. Expect jtarget=32'h00400000 and is_jtype=1.
- Back-pressure: hold out_ready=0 and offer beats A, B, C.
  - A is presented, B goes to skid, in_ready=0, and C is stalled.
  - Release out_ready. Output order must be A, B, C with no gaps after the skid drains.
- With main and skid both full, assert flush alongside in_valid. Next cycle: out_valid=0, in_ready=1, and the flushed beats never appear.
- Assert rst for one cycle mid-stream. Expect out_valid=0 and all field outputs 0, then a normal restart.
